m_drop_engine: RTL and testbench

- Board-state engine for the 7x6 connect-four game.
- Accepts one move request at a time (column, player) on a valid/ready handshake from the move chooser (user input path or AI).
- Drops the piece into the lowest empty row, updates the two field bitmaps consumed by the colour generator, then runs a bounded sequential four-in-a-row check and reports a result code.
- Sits directly upstream of m_get_color and owns the authoritative o_your_field / o_ai_field.

---
 rtl/m_drop_engine_pkg.sv | 19 +
 rtl/m_cell_probe.sv | 27 ++
 rtl/m_drop_engine.sv | 184 ++++++++++++++++++
 tb/tb_m_drop_engine.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/m_drop_engine_pkg.sv
// m_drop_engine_pkg: board geometry, result codes and FSM states shared by the drop engine
package m_drop_engine_pkg;
    localparam int COLS       = 7;
    localparam int ROWS       = 6;
    localparam int WIN_LEN    = 4;
    localparam int COL_SIZE   = 3;
    localparam int ROW_SIZE   = 3;
    localparam int FIELD_SIZE = COLS * ROWS;
    localparam int CNT_SIZE   = 6;

    localparam logic [2:0] RES_OK        = 3'd0;
    localparam logic [2:0] RES_COL_FULL  = 3'd1;
    localparam logic [2:0] RES_BAD_COL   = 3'd2;
    localparam logic [2:0] RES_WIN       = 3'd3;
    localparam logic [2:0] RES_DRAW      = 3'd4;
    localparam logic [2:0] RES_GAME_OVER = 3'd5;

    typedef enum logic [2:0] {S_IDLE, S_FIND, S_PLACE, S_CHECK, S_DONE} state_t;
endpackage

// File: rtl/m_cell_probe.sv
// m_cell_probe: checks whether an offset cell lies on the board and belongs to a player
module m_cell_probe
    import m_drop_engine_pkg::*;
(
    input  logic [FIELD_SIZE-1:0] i_your_field,
    input  logic [FIELD_SIZE-1:0] i_ai_field,
    input  logic                  i_player,
    input  logic [COL_SIZE-1:0]   i_col,
    input  logic [ROW_SIZE-1:0]   i_row,
    input  logic signed [3:0]     i_dx,
    input  logic signed [3:0]     i_dy,
    output logic                  o_in_bounds,
    output logic                  o_owned
);
    logic signed [4:0]     w_c;
    logic signed [4:0]     w_r;
    logic [5:0]            w_idx;
    logic [FIELD_SIZE-1:0] w_sel;

    assign w_c         = $signed({2'b00, i_col}) + $signed({i_dx[3], i_dx});
    assign w_r         = $signed({2'b00, i_row}) + $signed({i_dy[3], i_dy});
    assign o_in_bounds = (w_c >= 5'sd0) && (w_c < 5'(COLS)) && (w_r >= 5'sd0) && (w_r < 5'(ROWS));
    // off-board offsets collapse to index 0 and are masked, so the field is never indexed by them
    assign w_idx       = o_in_bounds ? 6'(w_c[2:0]) * 6'(ROWS) + 6'(w_r[2:0]) : 6'd0;
    assign w_sel       = i_player ? i_ai_field : i_your_field;
    assign o_owned     = o_in_bounds & w_sel[w_idx];
endmodule

// File: rtl/m_drop_engine.sv
// m_drop_engine: connect-four board state, gravity drop and sequential four-in-a-row check
module m_drop_engine
    import m_drop_engine_pkg::*;
(
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [COL_SIZE-1:0]   i_col,
    input  logic                  i_player,
    output logic                  o_done,
    output logic [2:0]            o_result,
    output logic [COL_SIZE-1:0]   o_last_col,
    output logic [ROW_SIZE-1:0]   o_last_row,
    output logic [CNT_SIZE-1:0]   o_move_cnt,
    output logic                  o_game_over,
    output logic [FIELD_SIZE-1:0] o_your_field,
    output logic [FIELD_SIZE-1:0] o_ai_field
);
    state_t                r_state;
    logic                  r_ready;
    logic                  r_done;
    logic                  r_player;
    logic                  r_game_over;
    logic                  r_half;
    logic                  r_broken;
    logic                  r_win;
    logic [2:0]            r_result;
    logic [COL_SIZE-1:0]   r_col;
    logic [COL_SIZE-1:0]   r_last_col;
    logic [ROW_SIZE-1:0]   r_row;
    logic [ROW_SIZE-1:0]   r_last_row;
    logic [CNT_SIZE-1:0]   r_move_cnt;
    logic [FIELD_SIZE-1:0] r_your;
    logic [FIELD_SIZE-1:0] r_ai;
    logic [1:0]            r_dir;
    logic [1:0]            r_step;
    logic [2:0]            r_cnt;

    logic [5:0]            w_idx;
    logic [FIELD_SIZE-1:0] w_bit;
    logic                  w_busy;
    logic                  w_in_bounds;
    logic                  w_owned;
    logic                  w_hit;
    logic                  w_last;
    logic                  w_dir_win;
    logic                  w_any_win;
    logic                  w_full;
    logic [2:0]            w_cnt_next;
    logic signed [3:0]     w_ux;
    logic signed [3:0]     w_uy;
    logic signed [3:0]     w_mag;
    logic signed [3:0]     w_dx;
    logic signed [3:0]     w_dy;

    assign w_idx  = 6'(r_col) * 6'(ROWS) + 6'(r_row);
    assign w_bit  = FIELD_SIZE'(1) << w_idx;
    assign w_busy = r_your[w_idx] | r_ai[w_idx];

    // walk directions: horizontal, vertical, (+1,+1), (+1,-1); second half walks the negated step
    assign w_ux  = (r_dir == 2'd1) ? 4'sd0 : 4'sd1;
    assign w_uy  = (r_dir == 2'd0) ? 4'sd0 : (r_dir == 2'd3) ? -4'sd1 : 4'sd1;
    assign w_mag = $signed({2'b00, r_step});
    assign w_dx  = r_half ? -(w_ux * w_mag) : w_ux * w_mag;
    assign w_dy  = r_half ? -(w_uy * w_mag) : w_uy * w_mag;

    m_cell_probe u_probe (
        .i_your_field (r_your),
        .i_ai_field   (r_ai),
        .i_player     (r_player),
        .i_col        (r_col),
        .i_row        (r_row),
        .i_dx         (w_dx),
        .i_dy         (w_dy),
        .o_in_bounds  (w_in_bounds),
        .o_owned      (w_owned)
    );

    assign w_hit      = w_in_bounds & w_owned & ~r_broken;
    assign w_cnt_next = r_cnt + {2'b00, w_hit};
    assign w_last     = (r_step == 2'd3) & r_half;
    assign w_dir_win  = w_last & (w_cnt_next >= 3'(WIN_LEN - 1));
    assign w_any_win  = r_win | w_dir_win;
    assign w_full     = r_move_cnt == CNT_SIZE'(FIELD_SIZE);

    // move FSM: accept, probe bottom-up, place, walk four directions, report
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_player    <= 1'b0;
            r_game_over <= 1'b0;
            r_half      <= 1'b0;
            r_broken    <= 1'b0;
            r_win       <= 1'b0;
            r_result    <= RES_OK;
            r_col       <= '0;
            r_last_col  <= '0;
            r_row       <= '0;
            r_last_row  <= '0;
            r_move_cnt  <= '0;
            r_your      <= '0;
            r_ai        <= '0;
            r_dir       <= '0;
            r_step      <= 2'd1;
            r_cnt       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (i_valid) begin
                    r_ready  <= 1'b0;
                    r_col    <= i_col;
                    r_player <= i_player;
                    r_row    <= ROW_SIZE'(ROWS - 1);
                    if (r_game_over) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= RES_GAME_OVER;
                    end else if (i_col >= COL_SIZE'(COLS)) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= RES_BAD_COL;
                    end else begin
                        r_state <= S_FIND;
                    end
                end
                S_FIND: if (!w_busy) begin
                    r_state <= S_PLACE;
                end else if (r_row == '0) begin
                    r_state  <= S_DONE;
                    r_done   <= 1'b1;
                    r_result <= RES_COL_FULL;
                end else begin
                    r_row <= r_row - 1'b1;
                end
                S_PLACE: begin
                    r_your     <= r_player ? r_your : r_your | w_bit;
                    r_ai       <= r_player ? r_ai | w_bit : r_ai;
                    r_move_cnt <= r_move_cnt + 1'b1;
                    r_last_col <= r_col;
                    r_last_row <= r_row;
                    r_dir      <= '0;
                    r_half     <= 1'b0;
                    r_step     <= 2'd1;
                    r_cnt      <= '0;
                    r_broken   <= 1'b0;
                    r_win      <= 1'b0;
                    r_state    <= S_CHECK;
                end
                S_CHECK: begin
                    r_step   <= (r_step == 2'd3) ? 2'd1 : r_step + 1'b1;
                    r_half   <= (r_step == 2'd3) ? ~r_half : r_half;
                    r_broken <= (r_step == 2'd3) ? 1'b0 : r_broken | ~w_hit;
                    r_cnt    <= w_last ? 3'd0 : w_cnt_next;
                    r_dir    <= w_last ? r_dir + 1'b1 : r_dir;
                    r_win    <= w_any_win;
                    if (w_last && r_dir == 2'd3) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_result    <= w_any_win ? RES_WIN : w_full ? RES_DRAW : RES_OK;
                        r_game_over <= w_any_win | w_full;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready      = r_ready;
    assign o_done       = r_done;
    assign o_result     = r_result;
    assign o_last_col   = r_last_col;
    assign o_last_row   = r_last_row;
    assign o_move_cnt   = r_move_cnt;
    assign o_game_over  = r_game_over;
    assign o_your_field = r_your;
    assign o_ai_field   = r_ai;
endmodule

// File: tb/tb_m_drop_engine.sv
// tb_m_drop_engine: scoreboard bench with an independent board model for m_drop_engine
module tb_m_drop_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_player = 1'b0;
    logic [2:0]  i_col = 3'd0;
    logic        o_ready;
    logic        o_done;
    logic [2:0]  o_result;
    logic [2:0]  o_last_col;
    logic [2:0]  o_last_row;
    logic [5:0]  o_move_cnt;
    logic        o_game_over;
    logic [41:0] o_your_field;
    logic [41:0] o_ai_field;

    typedef struct {
        int          result;
        int          lat;
        logic [41:0] your;
        logic [41:0] ai;
        int          cnt;
        int          lcol;
        int          lrow;
        bit          go;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   board[7][6];
    int   m_cnt = 0;
    bit   m_go = 1'b0;
    int   m_lcol = 0;
    int   m_lrow = 0;

    m_drop_engine dut (
        .w_clk        (clk),
        .w_rst        (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_col        (i_col),
        .i_player     (i_player),
        .o_done       (o_done),
        .o_result     (o_result),
        .o_last_col   (o_last_col),
        .o_last_row   (o_last_row),
        .o_move_cnt   (o_move_cnt),
        .o_game_over  (o_game_over),
        .o_your_field (o_your_field),
        .o_ai_field   (o_ai_field)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic bit m_win(input int p);
        int dc[4] = '{1, 0, 1, 1};
        int dr[4] = '{0, 1, 1, -1};
        for (int d = 0; d < 4; d++)
            for (int c = 0; c < 7; c++)
                for (int r = 0; r < 6; r++) begin
                    bit all = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        int cc = c + k * dc[d];
                        int rr = r + k * dr[d];
                        if (cc < 0 || cc > 6 || rr < 0 || rr > 5) all = 1'b0;
                        else if (board[cc][rr] != p) all = 1'b0;
                    end
                    if (all) return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic logic [41:0] m_field(input int p);
        logic [41:0] f = '0;
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++)
                if (board[c][r] == p) f[c * 6 + r] = 1'b1;
        return f;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        board  = '{default: 0};
        m_cnt  = 0;
        m_go   = 1'b0;
        m_lcol = 0;
        m_lrow = 0;
    endtask

    task automatic move(input int col, input int p);
        exp_t e;
        exp_t g;
        int   occ = 0;
        int   row = -1;
        int   n;
        e.lat = 1;
        if (m_go) e.result = 5;
        else if (col >= 7) e.result = 2;
        else begin
            for (int r = 5; r >= 0; r--)
                if (board[col][r] != 0) occ++;
                else if (row < 0) row = r;
            if (row < 0) begin
                e.result = 1;
                e.lat    = 7;
            end else begin
                board[col][row] = p + 1;
                m_cnt++;
                m_lcol = col;
                m_lrow = row;
                e.lat  = occ + 27;
                if (m_win(p + 1)) begin
                    e.result = 3;
                    m_go     = 1'b1;
                end else if (m_cnt == 42) begin
                    e.result = 4;
                    m_go     = 1'b1;
                end else e.result = 0;
            end
        end
        e.your = m_field(1);
        e.ai   = m_field(2);
        e.cnt  = m_cnt;
        e.lcol = m_lcol;
        e.lrow = m_lrow;
        e.go   = m_go;
        sb.push_back(e);
        @(negedge clk);
        n = 0;
        while (!o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        i_valid  = 1'b1;
        i_col    = col[2:0];
        i_player = p[0];
        @(posedge clk);
        #1 i_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_done && n < 60);
        g = sb.pop_front();
        chk("done_seen", o_done, 1);
        chk("latency", n, g.lat);
        chk("result", o_result, g.result);
        chk("your_field", o_your_field, g.your);
        chk("ai_field", o_ai_field, g.ai);
        chk("move_cnt", o_move_cnt, g.cnt);
        chk("last_col", o_last_col, g.lcol);
        chk("last_row", o_last_row, g.lrow);
        chk("game_over", o_game_over, g.go);
        chk("overlap", o_your_field & o_ai_field, 0);
        @(negedge clk);
        chk("done_pulse", o_done, 0);
    endtask

    initial begin
        do_reset();
        chk("rst_ready", o_ready, 1);
        chk("rst_done", o_done, 0);
        chk("rst_result", o_result, 0);
        chk("rst_your", o_your_field, 0);
        chk("rst_ai", o_ai_field, 0);
        chk("rst_cnt", o_move_cnt, 0);
        chk("rst_over", o_game_over, 0);
        chk("rst_lcol", o_last_col, 0);
        chk("rst_lrow", o_last_row, 0);

        move(3, 0);
        chk("bit23", o_your_field[23], 1);
        move(7, 1);

        do_reset();
        for (int i = 0; i < 6; i++) move(0, i % 2);
        move(0, 0);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            move(i, 0);
            if (i < 3) move(6, 1);
        end
        move(4, 1);

        do_reset();
        move(2, 0); move(5, 1); move(2, 0); move(5, 1);
        move(2, 0); move(6, 1); move(2, 0);

        do_reset();
        move(0, 0); move(1, 1); move(2, 1); move(2, 1); move(2, 0);
        move(3, 1); move(3, 1); move(3, 1); move(3, 0); move(1, 0);

        do_reset();
        for (int c = 0; c < 7; c++)
            for (int r = 5; r >= 0; r--) move(c, ((r >> 1) + c) & 1);
        move(1, 0);

        do_reset();
        @(negedge clk);
        i_valid  = 1'b1;
        i_col    = 3'd3;
        i_player = 1'b0;
        @(posedge clk);
        #1 i_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_field", o_your_field, 64'd1 << 23);
        chk("mid_busy", o_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", o_ready, 1);
        chk("abort_your", o_your_field, 0);
        chk("abort_ai", o_ai_field, 0);
        chk("abort_cnt", o_move_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        board  = '{default: 0};
        m_cnt  = 0;
        m_go   = 1'b0;
        m_lcol = 0;
        m_lrow = 0;
        move(3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
